// File: rtl/minsoc_clock_sequencer.sv
// Startup and lock-supervision sequencer for the SoC clock primitive (DCM/DLL/PLL).
// Resets the primitive, filters its lock, times the system reset and bounds the retries.
module minsoc_clock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_FILTER    = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int RST_HOLD       = 64,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       soft_rst_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lost_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int MAX_A   = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int FLT_W   = $clog2(LOCK_FILTER + 1);

  localparam logic [CNT_W-1:0] DCM_LAST  = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [FLT_W-1:0]       flt_q;
  logic [3:0]             retry_q, retry_d;
  logic [7:0]             lost_q, lost_d;
  logic                   take_retry;
  logic                   timed_state;

  // locked_i is asynchronous to clk_i; the chain settles it before any decision uses it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    retry_d    = retry_q;
    lost_d     = lost_q;
    take_retry = 1'b0;
    case (state_q)
      ST_DCM_RST: begin
        if (cnt_q == DCM_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A completed filter outranks a timeout landing on the same cycle.
        if (lock_s && (flt_q == FLT_LAST)) state_d = ST_HOLD;
        else if (cnt_q == TO_LAST)         take_retry = 1'b1;
      end
      ST_HOLD: begin
        if (!lock_s) begin
          take_retry = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
          state_d = ST_DCM_RST;
        end else if (soft_rst_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_DCM_RST;
    endcase

    if (take_retry) begin
      if (retry_q == RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = ST_DCM_RST;
      end
    end
  end

  assign timed_state = (state_q == ST_DCM_RST) || (state_q == ST_WAIT_LOCK) || (state_q == ST_HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_DCM_RST;
      cnt_q     <= '0;
      flt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      dcm_rst_o <= 1'b1;
      sys_rst_o <= 1'b1;
      ready_o   <= 1'b0;
      fail_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      cnt_q   <= ((state_d != state_q) || !timed_state) ? '0 : cnt_q + 1'b1;
      // The filter only means something while waiting for lock; elsewhere it stays cleared.
      flt_q   <= ((state_q == ST_WAIT_LOCK) && lock_s) ? flt_q + 1'b1 : '0;
      // NOTE: outputs decode state_d so they move on the same edge as the state register.
      dcm_rst_o <= (state_d == ST_DCM_RST);
      sys_rst_o <= (state_d != ST_RUN);
      ready_o   <= (state_d == ST_RUN);
      fail_o    <= (state_d == ST_FAIL);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;
  assign lost_cnt_o  = lost_q;

endmodule

// File: tb/tb_minsoc_clock_sequencer.sv
// Self-checking bench for minsoc_clock_sequencer: a phase/elapsed-time model checked every
// cycle, plus directed scenarios with hand-computed edge counts.
module tb_minsoc_clock_sequencer;

  localparam int SYNC = 2;
  localparam int DCMC = 3;
  localparam int FLT  = 4;
  localparam int TO   = 32;
  localparam int HOLD = 8;
  localparam int MAXR = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       locked_i = 1'b0;
  logic       soft_rst_i = 1'b0;
  logic       dcm_rst_o, sys_rst_o, ready_o, fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lost_cnt_o;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  minsoc_clock_sequencer #(
    .SYNC_STAGES(SYNC), .DCM_RST_CYCLES(DCMC), .LOCK_FILTER(FLT),
    .LOCK_TIMEOUT(TO), .RST_HOLD(HOLD), .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
    .dcm_rst_o(dcm_rst_o), .sys_rst_o(sys_rst_o), .ready_o(ready_o), .fail_o(fail_o),
    .retry_cnt_o(retry_cnt_o), .lost_cnt_o(lost_cnt_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 DCM_RST, 1 WAIT_LOCK, 2 HOLD, 3 RUN, 4 FAIL. Timing is judged from the edge at
  // which the phase was entered and from the history of sampled locked_i values.
  int m_ph = 0, m_start = 0, m_edge = 0, m_retry = 0, m_lost = 0;
  bit m_hist[$];

  function automatic bit lock_seen(int n);
    if (n - SYNC >= 1) return m_hist[n - SYNC - 1];
    return 1'b0;
  endfunction

  function automatic void enter(int p);
    m_ph    = p;
    m_start = m_edge;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    bit ls;
    bit retry;
    int run;
    if (rst_i) begin
      m_ph = 0; m_start = 0; m_edge = 0; m_retry = 0; m_lost = 0;
      m_hist.delete();
    end else begin
      m_edge++;
      m_hist.push_back(locked_i);
      ls    = lock_seen(m_edge);
      retry = 1'b0;
      case (m_ph)
        0: if (m_edge - m_start == DCMC) enter(1);
        1: begin
          run = 0;
          for (int k = m_edge; k > m_start && lock_seen(k); k--) run++;
          if (run == FLT) enter(2);
          else if (m_edge - m_start == TO) retry = 1'b1;
        end
        2: begin
          if (!ls) retry = 1'b1;
          else if (m_edge - m_start == HOLD) begin enter(3); m_retry = 0; end
        end
        3: begin
          if (!ls) begin
            if (m_lost < 255) m_lost++;
            enter(0);
          end else if (soft_rst_i) enter(2);
        end
        default: ;
      endcase
      if (retry) begin
        if (m_retry == MAXR) enter(4);
        else begin m_retry++; enter(0); end
      end
    end
  end

  always @(negedge clk_i) begin
    check("state_o",     state_o,     m_ph);
    check("dcm_rst_o",   dcm_rst_o,   int'(m_ph == 0));
    check("sys_rst_o",   sys_rst_o,   int'(m_ph != 3));
    check("ready_o",     ready_o,     int'(m_ph == 3));
    check("fail_o",      fail_o,      int'(m_ph == 4));
    check("retry_cnt_o", retry_cnt_o, m_retry);
    check("lost_cnt_o",  lost_cnt_o,  m_lost);
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (state_o !== s && n < budget);
    check($sformatf("reach_state_%0d", s), state_o, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first_dcm_low, first_sys_low, ready15;
    bit saw_hold, saw_dcm;

    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_state",  state_o,   0);
    check("rst_dcm",    dcm_rst_o, 1);
    check("rst_sys",    sys_rst_o, 1);

    // Clean start
    locked_i = 1'b1;
    do_reset();
    first_dcm_low = 0; first_sys_low = 0; ready15 = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!dcm_rst_o && first_dcm_low == 0) first_dcm_low = e;
      if (!sys_rst_o && first_sys_low == 0) first_sys_low = e;
      if (e == 15) ready15 = ready_o;
    end
    check("dcm_rst_fall_edge", first_dcm_low, 3);
    check("sys_rst_fall_edge", first_sys_low, 15);
    check("ready_at_edge15",   ready15, 1);
    check("clean_retry",       retry_cnt_o, 0);

    // Lock timeout and recovery
    locked_i = 1'b0;
    do_reset();
    wait_state(3'd1, 10, n);   check("first_wl_edge", n, 3);
    wait_state(3'd0, 100, n);  check("wl_timeout_len", n, 32);
    check("retry_after_timeout", retry_cnt_o, 1);
    wait_state(3'd1, 10, n);   check("dcm_pulse_len", n, 3);
    locked_i = 1'b1;
    wait_state(3'd3, 100, n);  check("recovery_len", n, 14);
    check("recovered_retry", retry_cnt_o, 0);

    // Permanent failure
    locked_i = 1'b0;
    do_reset();
    wait_state(3'd4, 200, n);  check("fail_edge", n, 105);
    check("fail_retry", retry_cnt_o, 2);
    repeat (200) step();
    check("fail_held",    fail_o,    1);
    check("fail_sys_rst", sys_rst_o, 1);
    check("fail_state",   state_o,   4);
    rst_i = 1'b1;
    #1;
    check("rst_from_fail_state", state_o,   0);
    check("rst_from_fail_fail",  fail_o,    0);
    check("rst_from_fail_dcm",   dcm_rst_o, 1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Lock filter: runs of 3 never satisfy a filter of 4
    do_reset();
    saw_hold = 1'b0;
    for (int i = 0; i < 80; i++) begin
      locked_i = (i % 4) != 3;
      step();
      if (state_o == 3'd2) saw_hold = 1'b1;
    end
    check("filter_hold_never", saw_hold, 0);
    check("filter_retry",      retry_cnt_o, 2);
    check("filter_state",      state_o, 1);

    // Lock loss in RUN coinciding with soft reset
    locked_i = 1'b1;
    do_reset();
    wait_state(3'd3, 50, n);
    locked_i = 1'b0;
    step();
    step();
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    check("loss_state", state_o, 0);
    check("loss_lost",  lost_cnt_o, 1);
    check("loss_retry", retry_cnt_o, 0);
    for (int i = 1; i < 300; i++) begin
      locked_i = 1'b1;
      wait_state(3'd3, 60, n);
      locked_i = 1'b0;
      wait_state(3'd0, 10, n);
    end
    check("lost_saturated", lost_cnt_o, 255);

    // Soft reset in RUN
    locked_i = 1'b1;
    wait_state(3'd3, 60, n);
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    check("soft_to_hold", state_o,   2);
    check("soft_sys_rst", sys_rst_o, 1);
    saw_dcm = 1'b0;
    n = 0;
    while (sys_rst_o && n < 50) begin
      if (dcm_rst_o) saw_dcm = 1'b1;
      step();
      n++;
    end
    check("soft_hold_len", n, 8);
    check("soft_no_dcm",   saw_dcm, 0);
    check("soft_ready",    ready_o, 1);

    // Asynchronous reset in the middle of HOLD
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    step();
    step();
    check("mid_hold_state", state_o, 2);
    rst_i = 1'b1;
    #1;
    check("async_rst_lost",  lost_cnt_o,  0);
    check("async_rst_retry", retry_cnt_o, 0);
    check("async_rst_state", state_o,     0);
    check("async_rst_dcm",   dcm_rst_o,   1);
    check("async_rst_sys",   sys_rst_o,   1);
    check("async_rst_ready", ready_o,     0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) step();
    check("restart_ready", ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
